sine_freq_meter: RTL and testbench

Measures the period of the sine sample stream produced by the phase-counter/sine-table generator. It detects rising midscale crossings with hysteresis and counts valid samples between consecutive crossings. It reports each period with a one-cycle strobe and flags lock once successive periods agree. It sits on the receive/loopback side of the waveform path, so the sample stream's frequency (phase step `delta`) can be checked independently of the generator.

---
 rtl/sine_meas_pkg.sv | 15 +
 rtl/zc_hyst_detect.sv | 67 ++++++
 rtl/sine_freq_meter.sv | 123 ++++++++++++
 tb/tb_sine_freq_meter.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sine_meas_pkg.sv
// Shared definitions for the sine sample path: sample width, offset-binary
// zero level, crossing hysteresis and the crossing-detector state type.
package sine_meas_pkg;

  localparam int unsigned SAMPLE_W_DEF = 20;
  localparam logic [SAMPLE_W_DEF-1:0] MIDSCALE_DEF = 20'h80000;
  localparam logic [SAMPLE_W_DEF-1:0] HYST_DEF     = 20'h01000;

  typedef enum logic [1:0] {
    XS_ARM  = 2'd0,
    XS_LOW  = 2'd1,
    XS_HIGH = 2'd2
  } cross_state_e;

endpackage

// File: rtl/zc_hyst_detect.sv
// Rising midscale-crossing detector with hysteresis; advances only on valid samples.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   XS_ARM  | side unknown (reset / after timeout); next threshold decides
//   XS_LOW  | last threshold crossed was LO; reaching HI is a rising edge
//   XS_HIGH | last threshold crossed was HI; waiting for LO
module zc_hyst_detect
  import sine_meas_pkg::*;
#(
  parameter int unsigned         SAMPLE_W = SAMPLE_W_DEF,
  parameter logic [SAMPLE_W-1:0] MIDSCALE = MIDSCALE_DEF,
  parameter logic [SAMPLE_W-1:0] HYST     = HYST_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] sample,
  input  logic                force_arm,
  output logic                rise,
  output cross_state_e        state
);

  // One extra bit so HI/LO never wrap.
  localparam logic [SAMPLE_W:0] MID_X  = {1'b0, MIDSCALE};
  localparam logic [SAMPLE_W:0] HYST_X = {1'b0, HYST};
  localparam logic [SAMPLE_W:0] HI_X   = MID_X + HYST_X;
  localparam logic [SAMPLE_W:0] LO_X   = (MID_X >= HYST_X) ? (MID_X - HYST_X) : '0;

  cross_state_e      state_q, state_d;
  logic [SAMPLE_W:0] sample_x;
  logic              at_hi, at_lo;

  assign sample_x = {1'b0, sample};
  assign at_hi    = (sample_x >= HI_X);
  assign at_lo    = (sample_x <= LO_X);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= XS_ARM;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (sample_valid) begin
      if (force_arm) begin
        state_d = XS_ARM;
      end else begin
        unique case (state_q)
          XS_ARM: begin
            if (at_hi)      state_d = XS_HIGH;
            else if (at_lo) state_d = XS_LOW;
          end
          XS_LOW:  if (at_hi) state_d = XS_HIGH;
          XS_HIGH: if (at_lo) state_d = XS_LOW;
          default: state_d = XS_ARM;
        endcase
      end
    end
  end

  always_comb begin
    rise  = sample_valid && (state_q == XS_LOW) && at_hi;
    state = state_q;
  end

endmodule

// File: rtl/sine_freq_meter.sv
// Sine period meter: counts valid samples between rising midscale crossings,
// reports each period with a strobe, flags lock and loss of signal.
module sine_freq_meter
  import sine_meas_pkg::*;
#(
  parameter int unsigned         SAMPLE_W = SAMPLE_W_DEF,
  parameter int unsigned         CNT_W    = 16,
  parameter logic [SAMPLE_W-1:0] MIDSCALE = MIDSCALE_DEF,
  parameter logic [SAMPLE_W-1:0] HYST     = HYST_DEF,
  parameter int unsigned         LOCK_TOL = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] sample,
  output logic [CNT_W-1:0]    period_out,
  output logic                period_valid,
  output logic                locked,
  output logic                no_signal
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_PRE  = {{(CNT_W-1){1'b1}}, 1'b0};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] TOL_C    = CNT_W'(LOCK_TOL);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] prev_period_q, prev_period_d;
  logic             period_valid_q, period_valid_d;
  logic             locked_q, locked_d;
  logic             no_signal_q, no_signal_d;
  logic             have_ref_q, have_ref_d;
  logic             prev_ok_q, prev_ok_d;

  logic             rise, edge_hit, timeout;
  cross_state_e     xs_state;
  logic [CNT_W-1:0] period_new, period_diff;

  zc_hyst_detect #(
    .SAMPLE_W (SAMPLE_W),
    .MIDSCALE (MIDSCALE),
    .HYST     (HYST)
  ) u_detect (
    .clk          (clk),
    .reset        (reset),
    .sample_valid (sample_valid),
    .sample       (sample),
    .force_arm    (timeout),
    .rise         (rise),
    .state        (xs_state)
  );

  assign edge_hit = rise && (xs_state == XS_LOW);
  // Fires once, on the sample that takes the counter to saturation; the edge wins a tie.
  assign timeout  = sample_valid && !edge_hit && (cnt_q == CNT_PRE);

  assign period_new  = cnt_q + CNT_ONE;
  assign period_diff = (period_new >= prev_period_q) ? (period_new - prev_period_q)
                                                     : (prev_period_q - period_new);

  always_comb begin
    cnt_d          = cnt_q;
    period_d       = period_q;
    prev_period_d  = prev_period_q;
    period_valid_d = 1'b0;
    locked_d       = locked_q;
    no_signal_d    = no_signal_q;
    have_ref_d     = have_ref_q;
    prev_ok_d      = prev_ok_q;
    if (sample_valid) begin
      if (edge_hit) begin
        cnt_d       = '0;
        no_signal_d = 1'b0;
        if (have_ref_q) begin
          period_d       = period_new;
          period_valid_d = 1'b1;
          locked_d       = prev_ok_q && (period_diff <= TOL_C);
          prev_period_d  = period_new;
          prev_ok_d      = 1'b1;
        end else begin
          have_ref_d = 1'b1;
        end
      end else begin
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_ONE;
        if (timeout) begin
          no_signal_d = 1'b1;
          locked_d    = 1'b0;
          have_ref_d  = 1'b0;
          prev_ok_d   = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q          <= '0;
      period_q       <= '0;
      prev_period_q  <= '0;
      period_valid_q <= 1'b0;
      locked_q       <= 1'b0;
      no_signal_q    <= 1'b0;
      have_ref_q     <= 1'b0;
      prev_ok_q      <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      period_q       <= period_d;
      prev_period_q  <= prev_period_d;
      period_valid_q <= period_valid_d;
      locked_q       <= locked_d;
      no_signal_q    <= no_signal_d;
      have_ref_q     <= have_ref_d;
      prev_ok_q      <= prev_ok_d;
    end
  end

  assign period_out   = period_q;
  assign period_valid = period_valid_q;
  assign locked       = locked_q;
  assign no_signal    = no_signal_q;

endmodule

// File: tb/tb_sine_freq_meter.sv
// Bench for sine_freq_meter: sine/noise/constant stimulus against a
// sample-index based reference model.
module tb_sine_freq_meter;

  localparam int CW = 16;
  localparam logic [19:0] HI_T = 20'h81000;
  localparam logic [19:0] LO_T = 20'h7F000;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          sample_valid = 1'b0;
  logic [19:0]   sample = 20'h80000;
  logic [CW-1:0] period_out;
  logic          period_valid, locked, no_signal;

  int n_checks = 0;
  int n_fail   = 0;

  logic [19:0] sine_tab [256];
  logic [7:0]  phase = 8'd0;

  // Reference model: positions are valid-sample indices; period = index gap between edges.
  int          m_side;      // 0 unknown, 1 below LO seen last, 2 above HI seen last
  longint      m_k, m_last, m_prev;
  bit          m_have_ref, m_prev_ok, m_timed_out;
  logic [CW-1:0] m_period;
  logic        m_pv, m_locked, m_nosig;

  sine_freq_meter dut (
    .clk          (clk),
    .reset        (reset),
    .sample_valid (sample_valid),
    .sample       (sample),
    .period_out   (period_out),
    .period_valid (period_valid),
    .locked       (locked),
    .no_signal    (no_signal)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_side = 0; m_k = 0; m_last = 0; m_prev = 0;
    m_have_ref = 0; m_prev_ok = 0; m_timed_out = 0;
    m_period = '0; m_pv = 0; m_locked = 0; m_nosig = 0;
  endtask

  task automatic model_step(input logic v, input logic [19:0] s);
    bit hi, lo, is_edge;
    longint p, d;
    m_pv = 0;
    if (!v) return;
    m_k++;
    hi = (s >= HI_T);
    lo = (s <= LO_T);
    is_edge = (m_side == 1) && hi;
    if (hi) m_side = 2;
    else if (lo) m_side = 1;
    if (is_edge) begin
      m_nosig = 0;
      m_timed_out = 0;
      if (m_have_ref) begin
        p = m_k - m_last;
        d = (p > m_prev) ? p - m_prev : m_prev - p;
        m_locked = m_prev_ok && (d <= 2);
        m_prev = p;
        m_prev_ok = 1;
        m_period = CW'(p);
        m_pv = 1;
      end else begin
        m_have_ref = 1;
      end
      m_last = m_k;
    end else if (!m_timed_out && (m_k - m_last == 65535)) begin
      m_timed_out = 1; m_nosig = 1; m_locked = 0;
      m_have_ref = 0; m_prev_ok = 0; m_side = 0;
    end
  endtask

  task automatic drive(input logic v, input logic [19:0] s);
    @(negedge clk);
    sample_valid = v;
    sample = s;
    @(posedge clk);
    #1;
    model_step(v, s);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    sample_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (period_out !== '0) begin n_fail++; $display("FAIL reset_period got=%0d want=0", period_out); end
    n_checks++; if (period_valid !== 1'b0) begin n_fail++; $display("FAIL reset_pv got=%b want=0", period_valid); end
    n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked got=%b want=0", locked); end
    n_checks++; if (no_signal !== 1'b0) begin n_fail++; $display("FAIL reset_nosig got=%b want=0", no_signal); end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  // Continuous tone from the phase generator; periods after settling must sit in [pmin,pmax] and be locked.
  task automatic test_tone(input string name, input int delta, input int nsamp,
                           input int vpct, input int pmin, input int pmax);
    int reports = 0;
    logic v;
    for (int i = 0; i < nsamp; i++) begin
      v = ($urandom_range(99) < vpct);
      drive(v, sine_tab[phase]);
      if (v) phase = phase + 8'(delta);
      n_checks++;
      if (period_valid !== m_pv || period_out !== m_period || locked !== m_locked || no_signal !== m_nosig) begin
        n_fail++;
        $display("FAIL %s i=%0d period=%0d/%0d pv=%b/%b locked=%b/%b nosig=%b/%b (got/want)",
                 name, i, period_out, m_period, period_valid, m_pv, locked, m_locked, no_signal, m_nosig);
      end
      if (period_valid === 1'b1) begin
        reports++;
        if (reports >= 3) begin
          n_checks++;
          if (period_out < CW'(pmin) || period_out > CW'(pmax) || locked !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_settled rpt=%0d period=%0d want %0d..%0d locked=%b want 1",
                     name, reports, period_out, pmin, pmax, locked);
          end
        end
      end
    end
    n_checks++;
    if (reports < 4) begin
      n_fail++;
      $display("FAIL %s_reports got=%0d want>=4", name, reports);
    end
  endtask

  task automatic test_noise();
    int pv_seen = 0;
    logic [19:0] s;
    for (int i = 0; i < 300; i++) begin
      s = 20'h80000 - 20'hFFF + 20'($urandom_range(32'h1FFE));
      drive(1'b1, s);
      n_checks++;
      if (period_valid !== m_pv || period_out !== m_period || locked !== m_locked) begin
        n_fail++;
        $display("FAIL noise i=%0d period=%0d/%0d pv=%b/%b locked=%b/%b (got/want)",
                 i, period_out, m_period, period_valid, m_pv, locked, m_locked);
      end
      if (period_valid === 1'b1) pv_seen++;
    end
    n_checks++;
    if (pv_seen != 0) begin n_fail++; $display("FAIL noise_strobes got=%0d want=0", pv_seen); end
  endtask

  task automatic test_reset_mid();
    int rpt = 0;
    int i = 0;
    while (m_locked !== 1'b1 && i < 1500) begin
      drive(1'b1, sine_tab[phase]); phase = phase + 8'd1; i++;
    end
    n_checks++;
    if (locked !== 1'b1) begin n_fail++; $display("FAIL rstmid_prelock got=%b want=1", locked); end
    for (int j = 0; j < 100; j++) begin drive(1'b1, sine_tab[phase]); phase = phase + 8'd1; end
    @(negedge clk);
    #2;
    sample_valid = 1'b0;
    reset = 1'b1;
    #1;
    n_checks++;
    if (period_out !== '0 || period_valid !== 1'b0 || locked !== 1'b0 || no_signal !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_clear period=%0d pv=%b locked=%b nosig=%b want all 0",
               period_out, period_valid, locked, no_signal);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    i = 0;
    while (rpt < 2 && i < 1200) begin
      drive(1'b1, sine_tab[phase]); phase = phase + 8'd1; i++;
      n_checks++;
      if (period_valid !== m_pv || period_out !== m_period || locked !== m_locked) begin
        n_fail++;
        $display("FAIL rstmid_relock i=%0d period=%0d/%0d pv=%b/%b locked=%b/%b (got/want)",
                 i, period_out, m_period, period_valid, m_pv, locked, m_locked);
      end
      if (period_valid === 1'b1) begin
        rpt++;
        n_checks++;
        if (locked !== (rpt == 2) || period_out !== 16'd256) begin
          n_fail++;
          $display("FAIL rstmid_rpt%0d period=%0d want 256 locked=%b want %b", rpt, period_out, locked, rpt == 2);
        end
      end
    end
    n_checks++;
    if (rpt < 2) begin n_fail++; $display("FAIL rstmid_timeout reports=%0d want 2", rpt); end
  endtask

  task automatic test_timeout();
    int rpt = 0;
    int i = 0;
    bit cleared_early = 0;
    for (int j = 0; j < 800; j++) begin drive(1'b1, sine_tab[phase]); phase = phase + 8'd1; end
    n_checks++;
    if (locked !== 1'b1) begin n_fail++; $display("FAIL timeout_prelock got=%b want=1", locked); end
    for (int j = 0; j < 65600; j++) begin
      drive(1'b1, 20'h80000);
      n_checks++;
      if (no_signal !== m_nosig || locked !== m_locked || period_valid !== m_pv) begin
        n_fail++;
        $display("FAIL timeout_run j=%0d nosig=%b/%b locked=%b/%b pv=%b/%b (got/want)",
                 j, no_signal, m_nosig, locked, m_locked, period_valid, m_pv);
      end
    end
    n_checks++;
    if (no_signal !== 1'b1 || locked !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_state nosig=%b want 1 locked=%b want 0", no_signal, locked);
    end
    phase = 8'd0;
    while (rpt < 1 && i < 1000) begin
      drive(1'b1, sine_tab[phase]); phase = phase + 8'd1; i++;
      n_checks++;
      if (no_signal !== m_nosig || period_valid !== m_pv || period_out !== m_period) begin
        n_fail++;
        $display("FAIL timeout_restart i=%0d nosig=%b/%b pv=%b/%b period=%0d/%0d (got/want)",
                 i, no_signal, m_nosig, period_valid, m_pv, period_out, m_period);
      end
      if (period_valid === 1'b1) begin
        rpt++;
        if (no_signal !== 1'b0) cleared_early = 1;
        n_checks++;
        if (period_out !== 16'd256 || locked !== 1'b0 || cleared_early) begin
          n_fail++;
          $display("FAIL timeout_first_rpt period=%0d want 256 locked=%b want 0 nosig=%b want 0",
                   period_out, locked, no_signal);
        end
      end
    end
    n_checks++;
    if (rpt < 1) begin n_fail++; $display("FAIL timeout_restart_bound reports=%0d want 1", rpt); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++)
      sine_tab[i] = 20'($rtoi(524288.0 + 524287.0 * $sin(2.0 * 3.14159265358979 * i / 256.0)));
    model_reset();
    test_reset();
    test_tone("delta1", 1, 1536, 100, 256, 256);
    test_tone("delta4", 4, 640, 100, 64, 64);
    test_tone("delta3", 3, 700, 100, 85, 86);
    test_tone("delta8_half", 8, 700, 50, 32, 32);
    test_noise();
    test_reset_mid();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
